// File: rtl/gray_step_monitor_pkg.sv
// Shared types for the gray step monitor: FSM state and step class encodings.
package gray_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        STEP_NONE = 3'd0,
        STEP_UP   = 3'd1,
        STEP_DN   = 3'd2,
        STEP_HOLD = 3'd3,
        STEP_ERR  = 3'd4
    } step_t;

endpackage

// File: rtl/gray_to_bin.sv
// Combinational gray-to-binary decode, MSB first.
module gray_to_bin #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] i_gray,
    output logic [W-1:0] o_bin
);

    logic [W-1:0] w_bin;

    always_comb begin
        w_bin        = '0;
        w_bin[W-1]   = i_gray[W-1];
        for (int i = int'(W) - 2; i >= 0; i--) begin
            w_bin[i] = w_bin[i+1] ^ i_gray[i];
        end
    end

    assign o_bin = w_bin;

endmodule

// File: rtl/gray_step_monitor.sv
// Samples a gray-coded counter, decodes it and classifies each step as up/down/hold/illegal.
// Define GRAY_SYNC_EN to add a two-flop synchronizer on gray_in (3-cycle latency).
module gray_step_monitor
    import gray_pkg::*;
#(
    parameter int unsigned W         = 4,
    parameter int unsigned ERR_LIMIT = 3,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     gray_in,
    input  logic             sample_en,
    input  logic             clr,
    output logic [W-1:0]     bin_out,
    output logic             valid,
    output logic             step_up,
    output logic             step_dn,
    output logic             step_hold,
    output logic             step_err,
    output logic [CNT_W-1:0] err_count,
    output logic             fault
);

    localparam int unsigned CONSEC_W = (ERR_LIMIT < 2) ? 1 : $clog2(ERR_LIMIT + 1);

    logic [W-1:0]        w_gray;
    logic                w_sample;
    logic [W-1:0]        w_bin;
    logic [W-1:0]        w_diff;
    step_t               w_step;

    state_t              r_state, w_state_nxt;
    logic [W-1:0]        r_prev, w_prev_nxt;
    logic [W-1:0]        r_bin, w_bin_nxt;
    logic                r_valid, w_valid_nxt;
    logic [3:0]          r_flags, w_flags_nxt;   // {up, dn, hold, err}
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic [CONSEC_W-1:0] r_consec, w_consec_nxt;
    logic                r_fault;

`ifdef GRAY_SYNC_EN
    logic [W-1:0] r_sync1, r_sync2;
    logic         r_se1, r_se2;

    // sample_en travels alongside the synchronized word so they stay aligned
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_se1   <= 1'b0;
            r_se2   <= 1'b0;
        end else begin
            r_sync1 <= gray_in;
            r_sync2 <= r_sync1;
            r_se1   <= sample_en;
            r_se2   <= r_se1;
        end
    end

    assign w_gray   = r_sync2;
    assign w_sample = r_se2;
`else
    assign w_gray   = gray_in;
    assign w_sample = sample_en;
`endif

    gray_to_bin #(.W(W)) u_dec (
        .i_gray (w_gray),
        .o_bin  (w_bin)
    );

    assign w_diff = w_bin - r_prev;

    // Binary adjacency decides legality, not gray Hamming distance
    always_comb begin
        w_step = STEP_ERR;
        if (w_diff == '0)
            w_step = STEP_HOLD;
        else if (w_diff == W'(1))
            w_step = STEP_UP;
        else if (w_diff == '1)
            w_step = STEP_DN;
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_prev_nxt   = r_prev;
        w_bin_nxt    = r_bin;
        w_valid_nxt  = 1'b0;
        w_flags_nxt  = r_flags;
        w_cnt_nxt    = r_cnt;
        w_consec_nxt = r_consec;

        if (clr) begin
            w_cnt_nxt    = '0;
            w_consec_nxt = '0;
            w_state_nxt  = ST_IDLE;
            if (w_sample) begin
                w_prev_nxt  = w_bin;
                w_bin_nxt   = w_bin;
                w_valid_nxt = 1'b1;
                w_flags_nxt = 4'b0000;
                w_state_nxt = ST_TRACK;
            end
        end else if (w_sample) begin
            w_prev_nxt  = w_bin;
            w_bin_nxt   = w_bin;
            w_valid_nxt = 1'b1;
            case (r_state)
                ST_IDLE: begin
                    w_flags_nxt = 4'b0000;
                    w_state_nxt = ST_TRACK;
                end
                ST_TRACK, ST_FAULT: begin
                    w_flags_nxt = {w_step == STEP_UP, w_step == STEP_DN,
                                   w_step == STEP_HOLD, w_step == STEP_ERR};
                    if (w_step == STEP_ERR) begin
                        if (r_cnt != '1)
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        if (r_consec != CONSEC_W'(ERR_LIMIT))
                            w_consec_nxt = r_consec + CONSEC_W'(1);
                        if (32'(r_consec) + 32'd1 >= 32'(ERR_LIMIT))
                            w_state_nxt = ST_FAULT;
                    end else begin
                        w_consec_nxt = '0;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev   <= '0;
            r_bin    <= '0;
            r_valid  <= 1'b0;
            r_flags  <= 4'b0000;
            r_cnt    <= '0;
            r_consec <= '0;
            r_fault  <= 1'b0;
        end else begin
            r_prev   <= w_prev_nxt;
            r_bin    <= w_bin_nxt;
            r_valid  <= w_valid_nxt;
            r_flags  <= w_flags_nxt;
            r_cnt    <= w_cnt_nxt;
            r_consec <= w_consec_nxt;
            r_fault  <= (w_state_nxt == ST_FAULT);
        end
    end

    assign bin_out   = r_bin;
    assign valid     = r_valid;
    assign step_up   = r_flags[3];
    assign step_dn   = r_flags[2];
    assign step_hold = r_flags[1];
    assign step_err  = r_flags[0];
    assign err_count = r_cnt;
    assign fault     = r_fault;

endmodule

// File: tb/tb_gray_step_monitor.sv
// Directed self-checking bench for gray_step_monitor (W=4, ERR_LIMIT=3, CNT_W=8).
module tb_gray_step_monitor;

    localparam int unsigned W     = 4;
    localparam int unsigned CNT_W = 8;
`ifdef GRAY_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [W-1:0]     gray_in = '0;
    logic             sample_en = 1'b0;
    logic             clr = 1'b0;
    logic [W-1:0]     bin_out;
    logic             valid;
    logic             step_up;
    logic             step_dn;
    logic             step_hold;
    logic             step_err;
    logic [CNT_W-1:0] err_count;
    logic             fault;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gray_step_monitor #(.W(W), .ERR_LIMIT(3), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .gray_in   (gray_in),
        .sample_en (sample_en),
        .clr       (clr),
        .bin_out   (bin_out),
        .valid     (valid),
        .step_up   (step_up),
        .step_dn   (step_dn),
        .step_hold (step_hold),
        .step_err  (step_err),
        .err_count (err_count),
        .fault     (fault)
    );

    // flags = {up, dn, hold, err}
    task automatic chk(input string tag, input logic [3:0] e_bin, input logic e_v,
                       input logic [3:0] e_flags, input logic [7:0] e_cnt, input logic e_f);
        logic [17:0] obs;
        logic [17:0] exp;
        obs = {bin_out, valid, step_up, step_dn, step_hold, step_err, err_count, fault};
        exp = {e_bin, e_v, e_flags, e_cnt, e_f};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%05h expected=%05h (bin,valid,up,dn,hold,err,cnt,fault)",
                   tag, obs, exp);
        end
    endtask

    // One-cycle sample pulse; returns at the falling edge where its result is visible
    task automatic smp(input logic [3:0] g);
        @(negedge clk);
        gray_in   = g;
        sample_en = 1'b1;
        @(negedge clk);
        sample_en = 1'b0;
        repeat (LAT - 1) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        sample_en = 1'b0;
        clr       = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset", 4'd0, 1'b0, 4'b0000, 8'd0, 1'b0);

        // count up from 0
        smp(4'b0000); chk("first_sample", 4'd0, 1'b1, 4'b0000, 8'd0, 1'b0);
        @(negedge clk); chk("valid_one_cycle", 4'd0, 1'b0, 4'b0000, 8'd0, 1'b0);
        smp(4'b0001); chk("up_1", 4'd1, 1'b1, 4'b1000, 8'd0, 1'b0);
        smp(4'b0011); chk("up_2", 4'd2, 1'b1, 4'b1000, 8'd0, 1'b0);
        smp(4'b0010); chk("up_3", 4'd3, 1'b1, 4'b1000, 8'd0, 1'b0);

        // wrap both directions
        do_reset();
        smp(4'b0000); chk("wrap_first", 4'd0, 1'b1, 4'b0000, 8'd0, 1'b0);
        smp(4'b1000); chk("down_wrap", 4'd15, 1'b1, 4'b0100, 8'd0, 1'b0);
        smp(4'b0000); chk("up_wrap", 4'd0, 1'b1, 4'b1000, 8'd0, 1'b0);

        // single gray bit change that is not binary-adjacent
        smp(4'b0100); chk("illegal_jump", 4'd7, 1'b1, 4'b0001, 8'd1, 1'b0);
        smp(4'b0101); chk("down_after_err", 4'd6, 1'b1, 4'b0100, 8'd1, 1'b0);

        // three consecutive illegal steps latch fault
        do_reset();
        smp(4'b0000); chk("fault_first", 4'd0, 1'b1, 4'b0000, 8'd0, 1'b0);
        smp(4'b0100); chk("err_1", 4'd7, 1'b1, 4'b0001, 8'd1, 1'b0);
        smp(4'b0000); chk("err_2", 4'd0, 1'b1, 4'b0001, 8'd2, 1'b0);
        smp(4'b0100); chk("err_3_fault", 4'd7, 1'b1, 4'b0001, 8'd3, 1'b1);
        smp(4'b0100); chk("hold_in_fault", 4'd7, 1'b1, 4'b0010, 8'd3, 1'b1);

        // clr together with a sample: behaves as the IDLE first sample
        @(negedge clk);
        gray_in   = 4'b0001;
        sample_en = 1'b1;
        clr       = 1'b1;
        @(negedge clk);
        sample_en = 1'b0;
        clr       = 1'b0;
        repeat (LAT - 1) @(negedge clk);
        chk("clr_with_sample", 4'd1, 1'b1, 4'b0000, 8'd0, 1'b0);
        smp(4'b0011); chk("up_after_clr", 4'd2, 1'b1, 4'b1000, 8'd0, 1'b0);
        smp(4'b0010); chk("up_to_3", 4'd3, 1'b1, 4'b1000, 8'd0, 1'b0);
        smp(4'b0110); chk("up_to_4", 4'd4, 1'b1, 4'b1000, 8'd0, 1'b0);
        smp(4'b0111); chk("up_to_5", 4'd5, 1'b1, 4'b1000, 8'd0, 1'b0);

        // reset mid-run with a concurrent sample: sample is discarded
        @(negedge clk);
        gray_in   = 4'b0101;
        sample_en = 1'b1;
        rst       = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        sample_en = 1'b0;
        chk("rst_mid_run", 4'd0, 1'b0, 4'b0000, 8'd0, 1'b0);
        repeat (LAT) @(negedge clk);
        chk("rst_sample_dropped", 4'd0, 1'b0, 4'b0000, 8'd0, 1'b0);
        smp(4'b0101); chk("idle_after_rst", 4'd6, 1'b1, 4'b0000, 8'd0, 1'b0);
        @(negedge clk); chk("no_sample_hold", 4'd6, 1'b0, 4'b0000, 8'd0, 1'b0);

        // error counter saturates at all-ones
        do_reset();
        smp(4'b0000);
        @(negedge clk);
        sample_en = 1'b1;
        for (int i = 0; i < 258; i++) begin
            gray_in = (i % 2 == 0) ? 4'b0100 : 4'b0000;
            @(negedge clk);
        end
        sample_en = 1'b0;
        repeat (LAT - 1) @(negedge clk);
        chk("err_saturate", 4'd0, 1'b1, 4'b0001, 8'hFF, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gray_step_monitor.md
Name: gray_step_monitor

Overview:
- Downstream consumer of the 4-bit gray-code up/down counter output.
- Samples the gray word, decodes it to binary and classifies each sampled step against the previous one: up, down, hold, or illegal.
- Counts illegal steps and latches a fault after consecutive illegal steps, so the counter can be checked in-system and by benches.

Parameters:
- W, 4, gray/binary word width (≥2).
- ERR_LIMIT, 3, consecutive illegal steps that force FAULT (≥1).
- CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- gray_in  input  W  gray word from the counter's register_out.
- sample_en  input  1  sample gray_in on this edge.
- clr  input  1  synchronous clear of errors/fault; returns the FSM to IDLE.
- bin_out  output  W  registered binary decode of the last sample.
- valid  output  1  one-cycle pulse: bin_out/step flags updated.
- step_up  output  1  last step was +1 (mod 2^W).
- step_dn  output  1  last step was −1 (mod 2^W).
- step_hold  output  1  last step was 0.
- step_err  output  1  last step was illegal (any other difference).
- err_count  output  CNT_W  total illegal steps, saturating at all-ones.
- fault  output  1  FSM in FAULT.

Behaviour:
- Decode: bin[W-1]=g[W-1]; bin[i]=bin[i+1]^g[i].
- Step diff d = bin_new − bin_prev, modulo 2^W:
  - d=1 → up; d=2^W−1 → down; d=0 → hold; otherwise illegal.
  - A single-bit gray change is not sufficient; binary adjacency is the criterion (e.g. 0000→0100 is illegal).
- Wrap-around: 2^W−1→0 is up; 0→2^W−1 is down; neither sets an error.
- Latency: on a sample_en edge, bin_out, the step flags and valid appear on the outputs after that edge (1-cycle latency). valid is high for exactly one cycle per sample. Step flags hold their value until the next sample; exactly one flag is set in TRACK.
- Reset (rst=1, takes priority over everything):
  - bin_out=0, valid=0, all step flags 0, err_count=0, fault=0, prev=0, consec=0, state=IDLE.
  - Applies mid-operation on the same edge; a sample in that cycle is discarded.
- FSM:
  - IDLE: the first sample loads prev and bin_out and pulses valid with all step flags 0 (no reference yet). → TRACK.
  - TRACK: each sample is classified.
    - Legal step: consec clears.
    - Illegal step: err_count+1 (saturating) and consec+1. When consec reaches ERR_LIMIT → FAULT.
    - prev always updates to the new sample, including after an illegal step.
  - FAULT: fault=1. Samples still decode, update bin_out and pulse valid. step_err=1 for illegal steps; err_count keeps counting. No exit except clr or rst.
- clr: err_count=0, consec=0, fault=0, state=IDLE; bin_out is retained.
  - clr and sample_en in the same cycle: clr wins and the sample is treated as the IDLE first sample (loads prev, flags 0).
- sample_en low: all registers hold, valid=0.

Optional Feature:
- GRAY_SYNC_EN.
- When defined: a two-flop synchronizer (reset to 0) on gray_in, for when the counter is in another clock domain. sample_en is delayed by 2 cycles alongside it, so end-to-end latency is 3 cycles from gray_in to valid.
- When undefined: gray_in is used directly, with 1-cycle latency.

Decomposition:
- Package gray_pkg:
  - state encoding ST_IDLE=2'd0, ST_TRACK=2'd1, ST_FAULT=2'd2.
  - step class codes STEP_NONE/UP/DN/HOLD/ERR.
- Sub-module gray_to_bin (combinational, parameter W). Instantiated once, on the current sample.

Test Plan:
- Reset, then samples gray 0000,0001,0011,0010 (W=4) → first valid with flags 0, bin_out 0; then bin_out 1,2,3 with step_up=1 each; err_count=0.
- Sample 0000, then 1000 → bin_out 15, step_dn=1. Then 0000 → bin_out 0, step_up=1 (wrap); no step_err.
- From 0000, sample 0100 → bin_out 7, step_err=1, err_count=1. Then sample 0101 → bin_out 6, step_dn=1, consec cleared, fault=0.
- ERR_LIMIT=3: from 0000 sample 0100, 0000, 0100 → three step_err pulses, fault=1 after the third, err_count=3. Assert clr with sample_en and gray 0001 → fault=0, err_count=0, valid with flags 0, bin_out 1.
- Assert rst mid-run while sample_en=1 with bin_out=5 → next cycle all outputs 0 and valid=0. The next sample is treated as an IDLE first sample.
- With GRAY_SYNC_EN defined: a single sample pulse → valid exactly 3 cycles after gray_in is applied; up/down classification unchanged.
